hgw_clk_idle_ctrl: RTL
======================

HGW_CLK_IDLE_CTRL -- requirements
Module: hgw_clk_idle_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (1..16).
REQ-002 Parameter IDLE_W, default 8: width of the idle-threshold counter.
REQ-003 Parameter WAKE_CYC, default 2: hw_en-high cycles in WAKE before returning to RUN (1..15).
REQ-004 clk_i  in  1  free-running clock; the block runs on the ungated clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ctrl_en  in  1  1 = auto-gating allowed; 0 = clock forced on.
REQ-007 idle_thr  in  IDLE_W  idle cycles required before gating.
REQ-008 busy_i  in  NREQ  per-requester activity, level.
REQ-009 wake_req  in  NREQ  per-requester wake request, level, held until acked.
REQ-010 wake_ack  out  NREQ  one-hot, one-cycle grant; the gated clock is guaranteed running.
REQ-011 hw_en  out  1  registered enable to the hw_en input of the downstream ICG wrapper.
REQ-012 gated_o  out  1  status: 1 while state is GATED.

Function
REQ-013 FSM states: RUN, COUNT, GATED, WAKE; state, hw_en, wake_ack and gated_o are all registered.
REQ-014 RUN: hw_en=1; moves to COUNT with cnt=0 when ctrl_en=1 and all of busy_i and wake_req are 0.
REQ-015 COUNT: hw_en=1; if any busy_i/wake_req bit is set or ctrl_en=0, moves to RUN; else if cnt>=idle_thr, moves to GATED; else cnt+1.
REQ-016 COUNT timing: idle_thr=N gives N+1 cycles in COUNT; idle_thr=0 gives exactly one COUNT cycle.
REQ-017 Simultaneous activity and threshold hit in COUNT: activity wins, go to RUN, no gating.
REQ-018 GATED: hw_en=0, gated_o=1; any busy_i/wake_req bit, or ctrl_en=0, moves to WAKE with wcnt=0.
REQ-019 WAKE: hw_en=1; wcnt increments; moves to RUN when wcnt==WAKE_CYC-1.
REQ-020 wake_ack is issued only in RUN and at most one bit per cycle, granted round-robin.
REQ-021 After a grant, the round-robin pointer moves to the bit after the granted one.
REQ-022 A requester is never granted in two consecutive cycles; it drops wake_req the cycle after its ack.
REQ-023 No grants are issued in COUNT, GATED or WAKE; pending requests wait, and wake_req in COUNT forces RUN.
REQ-024 ctrl_en=0 gives steady state RUN with hw_en=1; grants still operate.
REQ-025 Counter widths: cnt is IDLE_W bits and never wraps because the compare precedes the increment; wcnt is 4 bits.

Reset
REQ-026 rst_n low asynchronously forces: state RUN, hw_en=1 (clock on), gated_o=0, wake_ack=0, cnt=0, wcnt=0, RR pointer=0, stat_cnt=0.
REQ-027 Reset release is synchronous to clk_i, and the first transition can occur on the first clk_i edge after release.
REQ-028 Reset mid-GATED or mid-WAKE restores the clock on the same asynchronous assertion, with no wait for a clock edge.

Configuration
REQ-029 Macro HGW_CLK_IDLE_CTRL_STAT_EN defined: adds input stat_clr (1 bit) and output stat_cnt (32 bits).
REQ-030 stat_cnt increments each cycle gated_o=1 and saturates at 0xFFFFFFFF.
REQ-031 stat_clr=1 zeroes stat_cnt on the next edge, and clear takes priority over increment.
REQ-032 Macro undefined: stat_clr, stat_cnt and the counter logic are absent, and all other behaviour is identical.

Verification
REQ-033 ctrl_en=1, idle_thr=3, busy_i=wake_req=0 after reset -> hw_en falls exactly 5 edges later (1 RUN, 4 COUNT), and gated_o=1.
REQ-034 In GATED, wake_req=4'b0100 -> hw_en=1 the next edge, WAKE_CYC=2 cycles in WAKE, RUN, then wake_ack=4'b0100 for one cycle.
REQ-035 wake_req=4'b1011 held in RUN, pointer=0, each requester drops its request after ack -> acks 0001, 0010, 1000 on consecutive cycles.
REQ-036 idle_thr=5, busy_i[1] pulses in the cycle cnt==5 -> state RUN, hw_en never falls; COUNT restarts once busy_i clears.
REQ-037 GATED, then rst_n asserted between edges -> hw_en=1 immediately; after release, state is RUN.
REQ-038 With the macro, 10 GATED cycles then stat_clr=1 -> stat_cnt reads 10, then 0 the next edge; preloaded 0xFFFFFFFF stays saturated.

Source files
------------

// File: rtl/hgw_clk_idle_ctrl.sv
// Idle-driven clock-gate controller: RUN/COUNT/GATED/WAKE FSM with round-robin wake grants.
// Optional gated-cycle statistics counter when HGW_CLK_IDLE_CTRL_STAT_EN is defined.
module hgw_clk_idle_ctrl #(
    parameter int NREQ     = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              ctrl_en,
    input  logic [IDLE_W-1:0] idle_thr,
    input  logic [NREQ-1:0]   busy_i,
    input  logic [NREQ-1:0]   wake_req,
`ifdef HGW_CLK_IDLE_CTRL_STAT_EN
    input  logic              stat_clr,
    output logic [31:0]       stat_cnt,
`endif
    output logic [NREQ-1:0]   wake_ack,
    output logic              hw_en,
    output logic              gated_o
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_GATED = 2'd2;
    localparam logic [1:0] S_WAKE  = 2'd3;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

    logic [1:0]        state, state_nxt;
    logic [IDLE_W-1:0] cnt, cnt_nxt;
    logic [3:0]        wcnt, wcnt_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [NREQ-1:0]   ack_nxt;
    logic [NREQ-1:0]   elig;
    logic              wake_cond;

    assign wake_cond = (|busy_i) | (|wake_req) | ~ctrl_en;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wcnt_nxt  = wcnt;
        unique case (state)
            S_RUN: begin
                if (!wake_cond) begin
                    state_nxt = S_COUNT;
                    cnt_nxt   = '0;
                end
            end
            S_COUNT: begin
                // activity is checked first so it beats a threshold hit
                if (wake_cond) begin
                    state_nxt = S_RUN;
                end else if (cnt >= idle_thr) begin
                    state_nxt = S_GATED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GATED: begin
                if (wake_cond) begin
                    state_nxt = S_WAKE;
                    wcnt_nxt  = '0;
                end
            end
            S_WAKE: begin
                if (wcnt == WAKE_LAST) begin
                    state_nxt = S_RUN;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // a requester still holding wake_req during its ack cycle is masked out
    assign elig = wake_req & ~wake_ack;

    always_comb begin
        logic [PW:0] sum;
        logic        found;
        ack_nxt = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        sum     = '0;
        if (state == S_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                if (sum >= (PW+1)'(NREQ)) begin
                    sum = sum - (PW+1)'(NREQ);
                end
                if (!found && elig[sum[PW-1:0]]) begin
                    found                = 1'b1;
                    ack_nxt[sum[PW-1:0]] = 1'b1;
                    if (sum[PW-1:0] == PW'(NREQ - 1)) begin
                        ptr_nxt = '0;
                    end else begin
                        ptr_nxt = sum[PW-1:0] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            cnt      <= '0;
            wcnt     <= '0;
            ptr      <= '0;
            wake_ack <= '0;
            hw_en    <= 1'b1;
            gated_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wcnt     <= wcnt_nxt;
            ptr      <= ptr_nxt;
            wake_ack <= ack_nxt;
            hw_en    <= (state_nxt != S_GATED);
            gated_o  <= (state_nxt == S_GATED);
        end
    end

`ifdef HGW_CLK_IDLE_CTRL_STAT_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if (stat_clr) begin
            stat_cnt <= '0;
        end else if (gated_o && (stat_cnt != 32'hFFFF_FFFF)) begin
            stat_cnt <= stat_cnt + 32'd1;
        end
    end
`endif

endmodule
